// File: rtl/eka_pkg.sv
// Shared definitions for the Eka core front end: data widths, reset PC and
// the entry layout of the instruction buffer.
package eka_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;

  localparam logic [XLEN-1:0]   RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [INST_W-1:0] NOP              = 32'h0000_0013;

  typedef struct packed {
    logic [INST_W-1:0] data;
    logic [XLEN-1:0]   pc;
  } inst_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous show-ahead FIFO; the head entry is visible on dout
// whenever the FIFO is not empty. Push while full is accepted only with a pop.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_en;
  logic             pop_en;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign dout    = mem[rd_ptr_reg];
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_en)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CNT_W'(push_en) - CNT_W'(pop_en);
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues word-aligned fetches under a credit limit,
// buffers returned words with their PCs and squashes stale responses on redirect.
module fetch_unit
  import eka_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2,
  parameter int              CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [XLEN-1:0]   inst_pc
);

  logic [XLEN-1:0]  pc_reg;
  logic [CNT_W-1:0] inflight_reg;
  logic [CNT_W-1:0] inflight_next;
  logic [CNT_W-1:0] drop_reg;
  logic [CNT_W:0]   occupancy;
  logic             accept;
  logic             resp_keep;
  logic             inst_pop;

  logic [XLEN-1:0]  resp_pc;
  logic             pcq_full;
  logic             pcq_empty;
  logic [CNT_W-1:0] pcq_count;

  inst_entry_t      push_entry;
  inst_entry_t      head;
  logic             inst_full;
  logic             inst_empty;
  logic [CNT_W-1:0] inst_count;

  // Credit counts both requests still in memory and words already buffered.
  assign occupancy      = {1'b0, inflight_reg} + {1'b0, inst_count};
  assign imem_req_valid = !reset && !redirect_valid && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
  assign imem_req_addr  = pc_reg;
  assign accept         = imem_req_valid && imem_req_ready;
  assign inflight_next  = inflight_reg + CNT_W'(accept) - CNT_W'(imem_resp_valid);
  assign resp_keep      = imem_resp_valid && (drop_reg == '0) && !redirect_valid;
  assign push_entry     = '{data: imem_resp_data, pc: resp_pc};

  assign inst_valid = !reset && !inst_empty;
  assign inst_pop   = inst_valid && inst_ready && !redirect_valid;
  assign inst_data  = inst_valid ? head.data : '0;
  assign inst_pc    = inst_valid ? head.pc : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg       <= align_word(RESET_PC);
      inflight_reg <= '0;
      drop_reg     <= '0;
    end else begin
      inflight_reg <= inflight_next;
      if (redirect_valid) begin
        // Everything still in flight after this edge belongs to the old path.
        pc_reg   <= align_word(redirect_pc);
        drop_reg <= inflight_next;
      end else begin
        if (accept) pc_reg <= pc_reg + 32'd4;
        if (imem_resp_valid && (drop_reg != '0)) drop_reg <= drop_reg - CNT_W'(1);
      end
    end
  end

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_pc_queue (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .din   (pc_reg),
    .pop   (imem_resp_valid),
    .dout  (resp_pc),
    .full  (pcq_full),
    .empty (pcq_empty),
    .count (pcq_count)
  );

  // A redirect flushes the buffer on the same edge that loads the new PC.
  fetch_fifo #(.WIDTH(INST_W + XLEN), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_inst_buf (
    .clk   (clk),
    .reset (reset || redirect_valid),
    .push  (resp_keep),
    .din   (push_entry),
    .pop   (inst_pop),
    .dout  (head),
    .full  (inst_full),
    .empty (inst_empty),
    .count (inst_count)
  );

  a_resp_has_request: assert property (@(posedge clk) disable iff (reset)
    !(imem_resp_valid && pcq_empty));
  a_pcq_tracks_inflight: assert property (@(posedge clk) disable iff (reset)
    pcq_count == inflight_reg);
  a_pcq_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(accept && pcq_full && !imem_resp_valid));
  a_buf_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(resp_keep && inst_full && !inst_pop));

endmodule
